// File: rtl/fetch_inst_queue_if.sv
// fetch_inst_queue_if
//   Handshake bundle between the fetch stage (producer), the instruction queue
//   and decode (consumer).
//   Push side : in_valid, in_ready, in_mask, in_inst0/1, in_pc, in_pay0/1
//   Pop side  : out_valid, out_inst0/1, out_pc0/1, out_pay0/1, out_pop
//   Modports  : master = fetch/decode side driving the queue
//               slave  = the queue itself
interface fetch_inst_queue_if #(
  parameter int PAY_W = 45
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mask;
  logic [31:0]      in_inst0;
  logic [31:0]      in_inst1;
  logic [31:0]      in_pc;
  logic [PAY_W-1:0] in_pay0;
  logic [PAY_W-1:0] in_pay1;
  logic [1:0]       out_valid;
  logic [31:0]      out_inst0;
  logic [31:0]      out_inst1;
  logic [31:0]      out_pc0;
  logic [31:0]      out_pc1;
  logic [PAY_W-1:0] out_pay0;
  logic [PAY_W-1:0] out_pay1;
  logic [1:0]       out_pop;

  modport master (
    output in_valid, in_mask, in_inst0, in_inst1, in_pc, in_pay0, in_pay1, out_pop,
    input  in_ready, out_valid, out_inst0, out_inst1, out_pc0, out_pc1, out_pay0, out_pay1
  );

  modport slave (
    input  in_valid, in_mask, in_inst0, in_inst1, in_pc, in_pay0, in_pay1, out_pop,
    output in_ready, out_valid, out_inst0, out_inst1, out_pc0, out_pc1, out_pay0, out_pay1
  );
endinterface

// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue
//   Per-instruction fetch queue between IF1 and ID. Each two-lane fetch packet
//   is compacted by its lane mask into single-instruction entries {inst, pc, pay}
//   held in a circular buffer; decode sees the head two entries and pops 0..2.
// Ports
//   clk         clock
//   rstn        asynchronous active-low reset (clears pointers and count)
//   flush       discard all contents at the next edge; push/pop that cycle ignored
//   q_if        push/pop handshake bundle (slave modport)
//   count       occupied entries
//   nearly_full free entries < 2 + NF_MARGIN
// Build option
//   FETCH_QUEUE_BYPASS_EN : when the queue is empty, a firing push is presented
//   on the outputs in the same cycle and may be popped directly.
`ifndef INST_NOP
`define INST_NOP 32'h0340_0000
`endif

module fetch_inst_queue #(
  parameter int DEPTH     = 8,
  parameter int LOG_DEPTH = 3,
  parameter int PAY_W     = 45,
  parameter int NF_MARGIN = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  fetch_inst_queue_if.slave    q_if,
  output logic [LOG_DEPTH:0]   count,
  output logic                 nearly_full
);
  localparam int CW = LOG_DEPTH + 1;
  typedef logic [LOG_DEPTH-1:0] ptr_t;
  typedef logic [CW-1:0]        cnt_t;

  logic [31:0]      inst_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  logic [PAY_W-1:0] pay_mem  [DEPTH];

  ptr_t rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  cnt_t count_q, count_d;

  logic             in_ready;
  logic             push_fire;
  logic             bypass;
  logic [1:0]       pop_req, n_push, popped, mem_popped, skip, n_wr;
  cnt_t             avail;
  logic [31:0]      c_inst [2];
  logic [31:0]      c_pc   [2];
  logic [PAY_W-1:0] c_pay  [2];
  logic [31:0]      o_inst [2];
  logic [31:0]      o_pc   [2];
  logic [PAY_W-1:0] o_pay  [2];
  logic [1:0]       o_vld;

  // Readiness looks only at the registered count; a same-cycle pop never helps.
  assign in_ready  = (count_q <= cnt_t'(DEPTH - 2));
  assign push_fire = q_if.in_valid && in_ready && !flush;
  assign pop_req   = (q_if.out_pop == 2'd3) ? 2'd2 : q_if.out_pop;
  assign n_push    = push_fire ? (2'(q_if.in_mask[0]) + 2'(q_if.in_mask[1])) : 2'd0;

  // Lane compaction: slot 0 takes lane 0 if present, otherwise lane 1.
  // Slot 1 is only used for mask 11 and is always lane 1.
  assign c_inst[0] = q_if.in_mask[0] ? q_if.in_inst0 : q_if.in_inst1;
  assign c_pc[0]   = q_if.in_mask[0] ? q_if.in_pc    : q_if.in_pc + 32'd4;
  assign c_pay[0]  = q_if.in_mask[0] ? q_if.in_pay0  : q_if.in_pay1;
  assign c_inst[1] = q_if.in_inst1;
  assign c_pc[1]   = q_if.in_pc + 32'd4;
  assign c_pay[1]  = q_if.in_pay1;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = push_fire && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  // While bypassing, the visible entries are the incoming lanes; pops consume
  // them before they reach storage, so 'skip' lanes are dropped from the write.
  assign avail      = bypass ? cnt_t'(n_push) : count_q;
  assign popped     = (cnt_t'(pop_req) > avail) ? avail[1:0] : pop_req;
  assign mem_popped = bypass ? 2'd0 : popped;
  assign skip       = bypass ? popped : 2'd0;
  assign n_wr       = n_push - skip;

  always_comb begin
    rd_ptr_d = rd_ptr_q + ptr_t'(mem_popped);
    wr_ptr_d = wr_ptr_q + ptr_t'(n_wr);
    count_d  = count_q + cnt_t'(n_wr) - cnt_t'(mem_popped);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is intentionally not reset; count alone qualifies it.
  always_ff @(posedge clk) begin
    if (n_wr != 2'd0) begin
      inst_mem[wr_ptr_q] <= (skip == 2'd0) ? c_inst[0] : c_inst[1];
      pc_mem[wr_ptr_q]   <= (skip == 2'd0) ? c_pc[0]   : c_pc[1];
      pay_mem[wr_ptr_q]  <= (skip == 2'd0) ? c_pay[0]  : c_pay[1];
    end
    if (n_wr == 2'd2) begin
      inst_mem[wr_ptr_q + ptr_t'(1)] <= c_inst[1];
      pc_mem[wr_ptr_q + ptr_t'(1)]   <= c_pc[1];
      pay_mem[wr_ptr_q + ptr_t'(1)]  <= c_pay[1];
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd_lane
    ptr_t rd_addr;
    assign rd_addr    = rd_ptr_q + ptr_t'(gi);
    assign o_vld[gi]  = bypass ? (n_push > 2'(gi)) : (count_q > cnt_t'(gi));
    assign o_inst[gi] = !o_vld[gi] ? `INST_NOP : (bypass ? c_inst[gi] : inst_mem[rd_addr]);
    assign o_pc[gi]   = !o_vld[gi] ? 32'd0     : (bypass ? c_pc[gi]   : pc_mem[rd_addr]);
    assign o_pay[gi]  = !o_vld[gi] ? '0        : (bypass ? c_pay[gi]  : pay_mem[rd_addr]);
  end

  assign q_if.in_ready  = in_ready;
  assign q_if.out_valid = o_vld;
  assign q_if.out_inst0 = o_inst[0];
  assign q_if.out_inst1 = o_inst[1];
  assign q_if.out_pc0   = o_pc[0];
  assign q_if.out_pc1   = o_pc[1];
  assign q_if.out_pay0  = o_pay[0];
  assign q_if.out_pay1  = o_pay[1];

  assign count       = count_q;
  assign nearly_full = (cnt_t'(DEPTH) - count_q) < cnt_t'(2 + NF_MARGIN);
endmodule

// File: tb/tb_fetch_inst_queue.sv
// tb_fetch_inst_queue
//   Drives directed and random push/pop/flush traffic into fetch_inst_queue and
//   compares every cycle against a queue-based reference of the entry stream.
module tb_fetch_inst_queue;
  localparam int DEPTH     = 8;
  localparam int LOG_DEPTH = 3;
  localparam int PAY_W     = 45;
  localparam int NF_MARGIN = 2;
  localparam logic [31:0] NOP = 32'h0340_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0]      inst;
    logic [31:0]      pc;
    logic [PAY_W-1:0] pay;
  } entry_t;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               flush = 1'b0;
  logic [LOG_DEPTH:0] count;
  logic               nearly_full;

  fetch_inst_queue_if #(.PAY_W(PAY_W)) q_if();

  fetch_inst_queue #(
    .DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH), .PAY_W(PAY_W), .NF_MARGIN(NF_MARGIN)
  ) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .q_if(q_if.slave),
    .count(count), .nearly_full(nearly_full)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  entry_t mq[$];
  entry_t lanes[$];
  entry_t vis[$];
  entry_t e;
  bit     fire;
  int     avail, pop_n, free_n;

  always @(negedge clk) begin
    if (!rstn) mq.delete();
    vectors++;
    free_n = DEPTH - mq.size();
    fire = rstn && !flush && q_if.in_valid && (free_n >= 2);
    lanes.delete();
    if (fire) begin
      if (q_if.in_mask[0]) begin
        e.inst = q_if.in_inst0; e.pc = q_if.in_pc; e.pay = q_if.in_pay0;
        lanes.push_back(e);
      end
      if (q_if.in_mask[1]) begin
        e.inst = q_if.in_inst1; e.pc = q_if.in_pc + 32'd4; e.pay = q_if.in_pay1;
        lanes.push_back(e);
      end
    end
    if (BYP && fire && mq.size() == 0) vis = lanes;
    else vis = mq;

    chk("count", 64'(count), 64'(mq.size()));
    chk("in_ready", 64'(q_if.in_ready), 64'(free_n >= 2));
    chk("nearly_full", 64'(nearly_full), 64'(free_n < 2 + NF_MARGIN));
    chk("out_valid", 64'(q_if.out_valid), {62'd0, vis.size() >= 2, vis.size() >= 1});
    for (int k = 0; k < 2; k++) begin
      entry_t x;
      if (k < vis.size()) x = vis[k];
      else begin x.inst = NOP; x.pc = 32'd0; x.pay = '0; end
      chk(k == 0 ? "out_inst0" : "out_inst1", 64'(k == 0 ? q_if.out_inst0 : q_if.out_inst1), 64'(x.inst));
      chk(k == 0 ? "out_pc0" : "out_pc1", 64'(k == 0 ? q_if.out_pc0 : q_if.out_pc1), 64'(x.pc));
      chk(k == 0 ? "out_pay0" : "out_pay1", 64'(k == 0 ? q_if.out_pay0 : q_if.out_pay1), 64'(x.pay));
    end

    if (rstn) begin
      if (flush) mq.delete();
      else begin
        avail = (BYP && mq.size() == 0) ? lanes.size() : mq.size();
        pop_n = (q_if.out_pop == 2'd3) ? 2 : int'(q_if.out_pop);
        if (pop_n > avail) pop_n = avail;
        foreach (lanes[i]) mq.push_back(lanes[i]);
        repeat (pop_n) void'(mq.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] m, input logic [31:0] pc,
                       input logic [1:0] pop, input bit fl);
    q_if.in_valid = v;
    q_if.in_mask  = m;
    q_if.in_pc    = pc;
    q_if.in_inst0 = $urandom;
    q_if.in_inst1 = $urandom;
    q_if.in_pay0  = {$urandom, $urandom};
    q_if.in_pay1  = {$urandom, $urandom};
    q_if.out_pop  = pop;
    flush         = fl;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 32'd0, 2'd0, 1'b0);
  endtask

  logic [31:0] pc_run;

  initial begin
    idle();
    pc_run = 32'h1C00_0000;
    repeat (3) tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(q_if.in_ready), 64'd1);
    chk("rst_out_valid", 64'(q_if.out_valid), 64'd0);
    chk("rst_nearly_full", 64'(nearly_full), 64'd0);
    chk("rst_out_inst0", 64'(q_if.out_inst0), 64'(NOP));
    rstn = 1'b1;
    tick();

    // mask 11 push at 0x1C000000
    drive(1'b1, 2'b11, 32'h1C00_0000, 2'd0, 1'b0);
    q_if.in_inst0 = 32'h0000_0001;
    q_if.in_inst1 = 32'h0000_0002;
    #1;
    if (!BYP) chk("nobyp_out_valid", 64'(q_if.out_valid), 64'd0);
    tick(); idle(); #1;
    $display("push11 pc=1c000000 -> out_valid=%0b pc0=%h pc1=%h count=%0d",
             q_if.out_valid, q_if.out_pc0, q_if.out_pc1, count);
    chk("t1_out_valid", 64'(q_if.out_valid), 64'd3);
    chk("t1_out_pc0", 64'(q_if.out_pc0), 64'h1C00_0000);
    chk("t1_out_pc1", 64'(q_if.out_pc1), 64'h1C00_0004);
    chk("t1_out_inst1", 64'(q_if.out_inst1), 64'h2);
    chk("t1_count", 64'(count), 64'd2);

    // mask 10 push at 0x1C000008: single entry at pc+4
    drive(1'b1, 2'b10, 32'h1C00_0008, 2'd0, 1'b0);
    q_if.in_inst1 = 32'h0000_0022;
    tick(); idle(); #1;
    chk("t2_count", 64'(count), 64'd3);
    drive(1'b0, 2'b00, 32'd0, 2'd2, 1'b0);
    tick(); idle(); #1;
    $display("push10 pc=1c000008 -> head pc=%h inst=%h count=%0d", q_if.out_pc0, q_if.out_inst0, count);
    chk("t2_head_pc", 64'(q_if.out_pc0), 64'h1C00_000C);
    chk("t2_head_inst", 64'(q_if.out_inst0), 64'h22);
    chk("t2_count_after_pop", 64'(count), 64'd1);
    drive(1'b0, 2'b00, 32'd0, 2'd1, 1'b0);
    tick(); idle();

    // fill to DEPTH-1, then hold a push while full
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b11, pc_run, 2'd0, 1'b0); pc_run += 32'd8; tick();
    end
    drive(1'b1, 2'b01, pc_run, 2'd0, 1'b0); pc_run += 32'd8; tick();
    drive(1'b1, 2'b11, pc_run, 2'd0, 1'b0); #1;
    chk("full_in_ready", 64'(q_if.in_ready), 64'd0);
    tick();
    chk("full_count_held", 64'(count), 64'(DEPTH - 1));
    q_if.out_pop = 2'd2;
    tick(); idle(); #1;
    $display("fill %0d, pop 2 -> count=%0d in_ready=%0b", DEPTH - 1, count, q_if.in_ready);
    chk("full_pop_count", 64'(count), 64'(DEPTH - 3));
    chk("full_pop_in_ready", 64'(q_if.in_ready), 64'd1);
    drive(1'b0, 2'b00, 32'd0, 2'd2, 1'b0);
    repeat (DEPTH) tick();
    idle();

    // pop one per cycle over 3*DEPTH random pushes
    for (int i = 0; i < 3 * DEPTH; i++) begin
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), pc_run, 2'd1, 1'b0);
      pc_run += 32'd8;
      tick();
    end
    idle();

    // fully random traffic including over-pop and occasional flush
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), pc_run,
            2'($urandom_range(0, 3)), ($urandom_range(0, 31) == 0));
      pc_run += 32'd8;
      tick();
    end
    drive(1'b0, 2'b00, 32'd0, 2'd2, 1'b0);
    repeat (DEPTH) tick();
    idle();

    // flush at count 5 with a simultaneous push
    drive(1'b1, 2'b11, pc_run, 2'd0, 1'b0); pc_run += 32'd8; tick();
    drive(1'b1, 2'b11, pc_run, 2'd0, 1'b0); pc_run += 32'd8; tick();
    drive(1'b1, 2'b01, pc_run, 2'd0, 1'b0); pc_run += 32'd8; tick();
    idle(); #1;
    chk("pre_flush_count", 64'(count), 64'd5);
    drive(1'b1, 2'b11, pc_run, 2'd0, 1'b1);
    tick(); idle(); #1;
    $display("flush at count 5 + push -> count=%0d out_valid=%0b inst0=%h", count, q_if.out_valid, q_if.out_inst0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(q_if.out_valid), 64'd0);
    chk("flush_out_inst0", 64'(q_if.out_inst0), 64'(NOP));
    drive(1'b1, 2'b01, pc_run, 2'd0, 1'b0); pc_run += 32'd8; tick();
    drive(1'b0, 2'b00, 32'd0, 2'd2, 1'b0);
    tick(); idle(); #1;
    chk("overpop_count", 64'(count), 64'd0);
    tick();
    chk("overpop_count_hold", 64'(count), 64'd0);

    // empty queue, push 11 with pop 1
    drive(1'b1, 2'b11, 32'h1C00_0100, 2'd1, 1'b0);
    q_if.in_inst0 = 32'hAAAA_0001;
    q_if.in_inst1 = 32'hBBBB_0002;
    #1;
    if (BYP) begin
      chk("byp_out_inst0", 64'(q_if.out_inst0), 64'hAAAA_0001);
      chk("byp_out_valid", 64'(q_if.out_valid), 64'd3);
    end else begin
      chk("nobyp_out_valid2", 64'(q_if.out_valid), 64'd0);
    end
    tick(); idle(); #1;
    $display("push11 pop1 on empty -> count=%0d head=%h", count, q_if.out_inst0);
    if (BYP) begin
      chk("byp_count", 64'(count), 64'd1);
      chk("byp_head", 64'(q_if.out_inst0), 64'hBBBB_0002);
    end else begin
      chk("nobyp_count", 64'(count), 64'd2);
      chk("nobyp_head", 64'(q_if.out_inst0), 64'hAAAA_0001);
    end

    // asynchronous reset mid-operation
    drive(1'b1, 2'b11, pc_run, 2'd0, 1'b0); pc_run += 32'd8; tick();
    idle();
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_out_valid", 64'(q_if.out_valid), 64'd0);
    repeat (2) tick();
    rstn = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_inst_queue.md
# fetch_inst_queue

Parametrised per-instruction fetch queue between IF1 and ID, the next generation of the two-wide packet FIFO. Each two-instruction fetch packet is split into single-instruction entries with a per-lane valid mask, so misaligned fetch and partial issue need no bubbles. Decode pops 0, 1 or 2 instructions per cycle. Each entry carries its own PC and a per-instruction sideband payload (exception, excp_flag, priv/branch flags, cookie).

## Interface
- DEPTH, 8: entry count; power of two, at least 4.
- LOG_DEPTH, 3: log2(DEPTH).
- PAY_W, 45: per-instruction sideband width.
- NF_MARGIN, 2: extra free entries below which nearly_full asserts.

Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  discard all contents.
- in_valid  in  1  push request.
- in_ready  out  1  queue can accept a full packet.
- in_mask  in  2  lane valid; bit0 = inst0, bit1 = inst1.
- in_inst0, in_inst1  in  32  instructions.
- in_pc  in  32  PC of lane 0; lane 1 PC = in_pc+4.
- in_pay0, in_pay1  in  PAY_W  per-lane sideband.
- out_valid  out  2  bit k set when entry head+k is present.
- out_inst0, out_inst1  out  32  head and head+1 instruction.
- out_pc0, out_pc1  out  32  their PCs.
- out_pay0, out_pay1  out  PAY_W  their sideband.
- out_pop  in  2  number of entries consumed this cycle (0–2).
- count  out  LOG_DEPTH+1  occupied entries.
- nearly_full  out  1  free entries < 2+NF_MARGIN.

## Operation
- Storage: circular buffer of DEPTH entries {inst, pc, pay}; wr_ptr, rd_ptr, count.
- in_ready = (DEPTH − count) ≥ 2. Uses the current count only; same-cycle pops do not raise it.
- Push fires on in_valid && in_ready. Valid lanes are compacted in lane order and written at wr_ptr, wr_ptr+1 (mod DEPTH).
  - mask 01: writes inst0/in_pc.
  - mask 10: writes inst1/in_pc+4 into a single entry.
  - mask 11: writes two entries.
  - mask 00: accepted, writes nothing.
- pushed = popcount(mask) when the push fires, else 0.
- Pop: popped = min(out_pop, count). Over-pop is illegal but clamped; out_pop = 3 is treated as 2. rd_ptr advances by popped.
- count_next = count + pushed − popped; pointers wrap mod DEPTH.
- out_valid = {count ≥ 2, count ≥ 1}.
- Invalid output lane: inst = INST_NOP (shared define header), pc = 0, pay = 0.
- flush: count, rd_ptr and wr_ptr go to 0 at the next edge. A push or pop in the flush cycle is ignored. Outputs keep their current-cycle values until that edge.
- Reset: same clearing as flush, asynchronous. Entry storage is not reset. A mid-operation reset loses all contents.

## Timing
- Registered state; outputs are combinational from rd_ptr/count (read mux). No reset dependence beyond count.
- Push-to-visible latency: 1 cycle (bypass off).
- Pop takes effect at the edge; the next head is visible the following cycle.
- Simultaneous push and pop at count = DEPTH−2 is legal; count stays within [0, DEPTH].
- Reset values: in_ready = 1, out_valid = 00, count = 0, nearly_full = 0 (for DEPTH ≥ 4+NF_MARGIN), out_inst* = INST_NOP, out_pc* = 0, out_pay* = 0.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count = 0, a firing push drives its compacted lanes combinationally onto out_* and out_valid in the same cycle.
  - The same-cycle out_pop consumes them directly; only unpopped lanes are written.
  - flush still blocks the push.
- Undefined: no combinational path from in_* to out_*; 1-cycle latency always.

## Test plan
- Reset, then push mask 11 of 0x00000001/0x00000002 at pc 0x1C000000 -> next cycle: out_valid = 11, out_pc0 = 0x1C000000, out_pc1 = 0x1C000004, count = 2.
- Push mask 10 at pc 0x1C000008 -> one entry with inst1 and pc 0x1C00000C; count increments by 1.
- Fill to DEPTH−1 -> in_ready = 0, a held in_valid is not written; pop 2 -> in_ready = 1 next cycle.
- Pop 1 per cycle over 3·DEPTH random pushes, wrapping pointers -> PC sequence strictly in order, no loss or duplication.
- Flush with count = 5 plus simultaneous push -> next cycle count = 0, out_valid = 00, out_inst0 = INST_NOP; out_pop = 2 at count = 1 -> count = 0, no underflow.
- Bypass on, empty queue, push mask 11 with out_pop = 1 -> out_inst0 equals in_inst0 in the same cycle; next cycle count = 1 holding inst1. Bypass off -> out_valid = 00 in the push cycle.
